// File: rtl/aes_round_sched.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_sched
// Description : Iterative AES-128 encryption controller. Holds the 128-bit
//               cipher state and round-key registers and steps one external
//               single-round datapath plus one key-expansion step, one round
//               per clock. Block source and sink use valid/ready handshakes.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NR          number of rounds (10 for AES-128)
//   DW          block / key width in bits
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   in_valid    plaintext+key offered by the source
//   in_ready    controller can accept a block (IDLE only)
//   in_data     plaintext block
//   in_key      cipher key
//   out_valid   ciphertext valid (DONE)
//   out_ready   sink accepts ciphertext
//   out_data    ciphertext (state register)
//   busy        high while in RUN or DONE
//   rd_state    current state to the round datapath
//   rd_key      current round key to the key-expansion step
//   rd_rcon     round constant used by key expansion this cycle
//   rd_last     final round: datapath bypasses MixColumns
//   rd_state_nx round datapath result (uses rd_key_nx as its round key)
//   rd_key_nx   next round key from the key-expansion step
// ============================================================================
module aes_round_sched #(
    parameter int NR = 10,
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [DW-1:0] in_key,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic [DW-1:0] rd_state,
    output logic [DW-1:0] rd_key,
    output logic [7:0]    rd_rcon,
    output logic          rd_last,
    input  logic [DW-1:0] rd_state_nx,
    input  logic [DW-1:0] rd_key_nx
);

    // Round counter is wide enough to hold NR itself; it saturates at NR.
    localparam int RW = $clog2(NR + 1);
    localparam logic [RW-1:0] C_LAST_RND  = RW'(NR);
    localparam logic [RW-1:0] C_FIRST_RND = RW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    fsm_t          r_fsm;
    fsm_t          w_fsm_nx;
    logic [RW-1:0] r_rnd;
    logic [RW-1:0] w_rnd_nx;
    logic [DW-1:0] r_state_q;
    logic [DW-1:0] w_state_nx;
    logic [DW-1:0] r_key_q;
    logic [DW-1:0] w_key_nx;

    // AES round constants: successive doublings in GF(2^8) starting at 01
    // for round 1. Round indices outside 1..10 carry no constant.
    function automatic logic [7:0] rcon_of(input logic [RW-1:0] rnd);
        logic [7:0] rc;
        case (rnd)
            RW'(1):  rc = 8'h01;
            RW'(2):  rc = 8'h02;
            RW'(3):  rc = 8'h04;
            RW'(4):  rc = 8'h08;
            RW'(5):  rc = 8'h10;
            RW'(6):  rc = 8'h20;
            RW'(7):  rc = 8'h40;
            RW'(8):  rc = 8'h80;
            RW'(9):  rc = 8'h1b;
            RW'(10): rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm     <= ST_IDLE;
            r_rnd     <= '0;
            r_state_q <= '0;
            r_key_q   <= '0;
        end else begin
            r_fsm     <= w_fsm_nx;
            r_rnd     <= w_rnd_nx;
            r_state_q <= w_state_nx;
            r_key_q   <= w_key_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_fsm_nx   = r_fsm;
        w_rnd_nx   = r_rnd;
        w_state_nx = r_state_q;
        w_key_nx   = r_key_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        rd_rcon    = 8'h00;
        rd_last    = 1'b0;

        case (r_fsm)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Round-0 AddRoundKey is folded into the load so the
                    // shared datapath only ever sees full rounds.
                    w_state_nx = in_data ^ in_key;
                    w_key_nx   = in_key;
                    w_rnd_nx   = C_FIRST_RND;
                    w_fsm_nx   = ST_RUN;
                end
            end

            ST_RUN: begin
                busy       = 1'b1;
                rd_rcon    = rcon_of(r_rnd);
                rd_last    = (r_rnd == C_LAST_RND);
                w_state_nx = rd_state_nx;
                w_key_nx   = rd_key_nx;
                if (r_rnd == C_LAST_RND) begin
                    // Final round result is captured; counter holds at NR.
                    w_fsm_nx = ST_DONE;
                end else begin
                    w_rnd_nx = r_rnd + RW'(1);
                end
            end

            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_rnd_nx = '0;
                    w_fsm_nx = ST_IDLE;
                end
            end

            default: begin
                // Unused encoding: fall back to IDLE without touching data.
                w_rnd_nx = '0;
                w_fsm_nx = ST_IDLE;
            end
        endcase
    end

    // Ciphertext and datapath operands are taken straight from the registers
    // so they stay stable for the whole DONE backpressure window.
    assign out_data = r_state_q;
    assign rd_state = r_state_q;
    assign rd_key   = r_key_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_round_sched
// Description : Self-checking bench for aes_round_sched. Supplies a behavioural
//               AES round / key-expansion datapath and checks the controller
//               against FIPS-197 vectors and handshake/sequence expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_sched;

    localparam int NR = 10;
    localparam int DW = 128;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [DW-1:0] in_key;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;
    logic [DW-1:0] rd_state;
    logic [DW-1:0] rd_key;
    logic [7:0]    rd_rcon;
    logic          rd_last;
    logic [DW-1:0] rd_state_nx;
    logic [DW-1:0] rd_key_nx;

    int n_assert;
    int n_fail;

    localparam logic [DW-1:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [DW-1:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [DW-1:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [DW-1:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [DW-1:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [DW-1:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    aes_round_sched #(.NR(NR), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_key      (in_key),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .rd_state    (rd_state),
        .rd_key      (rd_key),
        .rd_rcon     (rd_rcon),
        .rd_last     (rd_last),
        .rd_state_nx (rd_state_nx),
        .rd_key_nx   (rd_key_nx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural AES round datapath (GF(2^8) arithmetic, S-box by
    // inversion + affine map)
    // ------------------------------------------------------------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv, pw, s;
        logic [7:0] e;
        inv = 8'h01; pw = x; e = 8'd254;   // x^254 = x^-1, and 0 -> 0
        for (int i = 0; i < 8; i++) begin
            if (e[i]) inv = gmul(inv, pw);
            pw = gmul(pw, pw);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [DW-1:0] aes_round(input logic [DW-1:0] st,
                                                input logic [DW-1:0] rk,
                                                input logic last);
        logic [7:0] b [16];
        logic [7:0] s [16];
        logic [7:0] a0, a1, a2, a3;
        logic [DW-1:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(st[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r+4*c] = b[r + 4*((c+r)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o ^ rk;
    endfunction

    function automatic logic [DW-1:0] key_exp(input logic [DW-1:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
             ^ {rc, 24'h000000};
        w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    always_comb begin
        rd_key_nx   = key_exp(rd_key, rd_rcon);
        rd_state_nx = aes_round(rd_state, rd_key_nx, rd_last);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking inside)
    // ------------------------------------------------------------------
    // Called at posedge+1 while IDLE; returns at posedge+1 after acceptance.
    task automatic send_block(input logic [DW-1:0] pt, input logic [DW-1:0] key);
        in_valid = 1'b1;
        in_data  = pt;
        in_key   = key;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        n_assert++;
        if ({in_ready, out_valid, busy, rd_last} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy/ov/busy/last=%b want 1000",
                     {in_ready, out_valid, busy, rd_last});
        end
        n_assert++;
        if (rd_rcon !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rcon: got %h want 00", rd_rcon);
        end
        n_assert++;
        if (out_data !== '0 || rd_state !== '0 || rd_key !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: out_data %h rd_key %h want 0", out_data, rd_key);
        end
    endtask

    task automatic test_fips_c1();
        logic [79:0] rc_tab;
        logic [7:0]  exp_rc;
        rc_tab = 80'h01020408102040801b36;
        out_ready = 1'b0;
        send_block(C1_PT, C1_KEY);              // now just after edge T
        for (int i = 1; i <= NR; i++) begin
            exp_rc = rc_tab[79-8*(i-1) -: 8];
            n_assert++;
            if (rd_rcon !== exp_rc) begin
                n_fail++;
                $display("FAIL c1_rcon[%0d]: got %h want %h", i, rd_rcon, exp_rc);
            end
            n_assert++;
            if (rd_last !== (i == NR)) begin
                n_fail++;
                $display("FAIL c1_last[%0d]: got %b want %b", i, rd_last, (i == NR));
            end
            n_assert++;
            if ({in_ready, out_valid, busy} !== 3'b001) begin
                n_fail++;
                $display("FAIL c1_run[%0d]: rdy/ov/busy=%b want 001", i,
                         {in_ready, out_valid, busy});
            end
            @(posedge clk); #1;
        end
        // After edge T+10
        n_assert++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || rd_last !== 1'b0 || rd_rcon !== 8'h00) begin
            n_fail++;
            $display("FAIL c1_latency: ov=%b rdy=%b last=%b rcon=%h want 1 0 0 00",
                     out_valid, in_ready, rd_last, rd_rcon);
        end
        n_assert++;
        if (out_data !== C1_CT) begin
            n_fail++;
            $display("FAIL c1_ct: got %h want %h", out_data, C1_CT);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;                     // edge T+11 handshake
        n_assert++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL c1_handshake: rdy/ov/busy=%b want 100", {in_ready, out_valid, busy});
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        out_ready = 1'b0;
        send_block(B_PT, B_KEY);
        wait_out_valid(20, ok);
        n_assert++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_timeout: out_valid got 0 want 1 within 20 cycles");
        end
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;                    // must be ignored in DONE
            in_data  = C1_PT;
            in_key   = C1_KEY;
            n_assert++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== B_CT) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: ov=%b rdy=%b data=%h want 1 0 %h",
                         i, out_valid, in_ready, out_data, B_CT);
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_assert++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL bp_release: rdy/ov/busy=%b want 100", {in_ready, out_valid, busy});
        end
        @(posedge clk); #1;
        n_assert++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL bp_idle_hold: rdy/ov/busy=%b want 100", {in_ready, out_valid, busy});
        end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        out_ready = 1'b1;
        send_block(C1_PT, C1_KEY);              // RUN cycle 1
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;                 // reach RUN cycle 5
        end
        n_assert++;
        if (rd_rcon !== 8'h10) begin
            n_fail++;
            $display("FAIL mid_rcon5: got %h want 10", rd_rcon);
        end
        rst = 1'b1;
        #1;                                     // no clock edge in between
        n_assert++;
        if ({in_ready, out_valid, busy, rd_last} !== 4'b1000 || rd_rcon !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_async_ctrl: rdy/ov/busy/last=%b rcon=%h want 1000 00",
                     {in_ready, out_valid, busy, rd_last}, rd_rcon);
        end
        n_assert++;
        if (out_data !== '0 || rd_key !== '0) begin
            n_fail++;
            $display("FAIL mid_async_regs: out_data %h rd_key %h want 0", out_data, rd_key);
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        send_block(B_PT, B_KEY);
        wait_out_valid(20, ok);
        n_assert++;
        if (!ok || out_data !== B_CT) begin
            n_fail++;
            $display("FAIL mid_after_reset_ct: ok=%b got %h want %h", ok, out_data, B_CT);
        end
        @(posedge clk); #1;
        n_assert++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_after_reset_idle: ov=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = C1_PT;
        in_key    = C1_KEY;
        @(posedge clk); #1;                     // edge T: first accepted
        in_data = B_PT;                         // held with in_valid=1 throughout
        in_key  = B_KEY;
        n_assert++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept1: busy=%b rdy=%b want 1 0", busy, in_ready);
        end
        for (int i = 0; i < NR - 1; i++) begin
            @(posedge clk); #1;
        end
        n_assert++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_early1: out_valid got 1 want 0 at T+9");
        end
        @(posedge clk); #1;                     // edge T+10
        n_assert++;
        if (out_valid !== 1'b1 || out_data !== C1_CT) begin
            n_fail++;
            $display("FAIL b2b_ct1: ov=%b got %h want 1 %h", out_valid, out_data, C1_CT);
        end
        @(posedge clk); #1;                     // edge T+11: handshake
        n_assert++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL b2b_idle_gap: rdy/ov/busy=%b want 100", {in_ready, out_valid, busy});
        end
        @(posedge clk); #1;                     // edge T+12: second accepted
        in_valid = 1'b0;
        n_assert++;
        if ({in_ready, busy} !== 2'b01 || rd_rcon !== 8'h01) begin
            n_fail++;
            $display("FAIL b2b_accept2: rdy/busy=%b rcon=%h want 01 01", {in_ready, busy}, rd_rcon);
        end
        for (int i = 0; i < NR; i++) begin
            @(posedge clk); #1;
        end
        n_assert++;
        if (out_valid !== 1'b1 || out_data !== B_CT) begin
            n_fail++;
            $display("FAIL b2b_ct2: ov=%b got %h want 1 %h", out_valid, out_data, B_CT);
        end
        @(posedge clk); #1;
        n_assert++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL b2b_final_idle: rdy/ov/busy=%b want 100", {in_ready, out_valid, busy});
        end
    endtask

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        out_ready = 1'b0;
        #1;
        test_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_fips_c1();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
